// File: rtl/sdf_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_delay_line
//  Description : Complex (R/I) run-time selectable delay line for single-path
//                delay feedback FFT stages. A circular buffer of MAX_DELAY
//                entries advances only on enabled samples; a fill tracker
//                marks when the registered output carries real data.
//                Optional feature macro: SDF_DELAY_BYPASS_EN (adds the
//                bypass port and a one-clock pass-through path).
//  Revision    : 1.0 - initial release
// ============================================================================
module sdf_delay_line #(
   parameter int WIDTH         = 24,
   parameter int MAX_DELAY     = 64,
   parameter int ADDR_W        = 6,
   parameter int DEFAULT_DELAY = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
`ifdef SDF_DELAY_BYPASS_EN
   input  logic              bypass,
`endif
   input  logic              cfg_load,
   input  logic [ADDR_W:0]   delay_sel,
   input  logic [WIDTH-1:0]  dataIn_R,
   input  logic [WIDTH-1:0]  dataIn_I,
   output logic [WIDTH-1:0]  dataOut_R,
   output logic [WIDTH-1:0]  dataOut_I,
   output logic              out_valid,
   output logic [ADDR_W:0]   delay_q
);

   // Delay limits expressed at the width of the delay / fill registers.
   localparam logic [ADDR_W:0] c_max_delay     = (ADDR_W+1)'(MAX_DELAY);
   localparam logic [ADDR_W:0] c_default_delay = (ADDR_W+1)'(DEFAULT_DELAY);
   localparam logic [ADDR_W:0] c_min_delay     = (ADDR_W+1)'(1);

   // Sample storage: real part in the upper half, imaginary in the lower.
   logic [2*WIDTH-1:0] mem [MAX_DELAY];

   // Registered state.
   logic [ADDR_W-1:0]  wr_ptr_q,     wr_ptr_d;
   logic [ADDR_W:0]    fill_cnt_q,   fill_cnt_d;
   logic [ADDR_W:0]    delay_d;
   logic [WIDTH-1:0]   dout_r_q,     dout_r_d;
   logic [WIDTH-1:0]   dout_i_q,     dout_i_d;
   logic               out_valid_q,  out_valid_d;

   // Combinational helpers.
   logic [2*WIDTH-1:0] w_din;
   logic [2*WIDTH-1:0] w_rd;
   logic [ADDR_W:0]    w_delay_clamped;
   logic               w_ptr_last;
   logic               w_line_full;
   logic               w_mem_we;

   assign w_din = {dataIn_R, dataIn_I};

   // Read happens before the write of the same beat, so the oldest sample
   // still lives at the write pointer when it is fetched.
   assign w_rd = mem[wr_ptr_q];

   // The pointer wraps at the active delay, not at the storage depth.
   assign w_ptr_last  = ({1'b0, wr_ptr_q} == (delay_q - c_min_delay));
   assign w_line_full = (fill_cnt_q == delay_q);

   // Requested delay is clamped into 1..MAX_DELAY before being latched.
   always_comb begin
      w_delay_clamped = delay_sel;
      if (delay_sel == '0) begin
         w_delay_clamped = c_min_delay;
      end else if (delay_sel > c_max_delay) begin
         w_delay_clamped = c_max_delay;
      end
   end

   // Memory is written only on ordinary delayed beats; loads and bypass
   // beats leave the stored history untouched.
   always_comb begin
      w_mem_we = en && !cfg_load;
`ifdef SDF_DELAY_BYPASS_EN
      if (bypass) begin
         w_mem_we = 1'b0;
      end
`endif
   end

   // Next-state logic: load has priority, then bypass, then a delayed beat.
   always_comb begin
      delay_d     = delay_q;
      wr_ptr_d    = wr_ptr_q;
      fill_cnt_d  = fill_cnt_q;
      dout_r_d    = dout_r_q;
      dout_i_d    = dout_i_q;
      out_valid_d = 1'b0;

      if (cfg_load) begin
         // Restart the line at the new depth; a coincident sample is dropped.
         delay_d    = w_delay_clamped;
         wr_ptr_d   = '0;
         fill_cnt_d = '0;
         dout_r_d   = '0;
         dout_i_d   = '0;
`ifdef SDF_DELAY_BYPASS_EN
      end else if (en && bypass) begin
         // Pass-through with one clock of latency; history is frozen.
         dout_r_d    = dataIn_R;
         dout_i_d    = dataIn_I;
         out_valid_d = 1'b1;
`endif
      end else if (en) begin
         wr_ptr_d = w_ptr_last ? '0 : (wr_ptr_q + 1'b1);
         if (w_line_full) begin
            dout_r_d    = w_rd[2*WIDTH-1:WIDTH];
            dout_i_d    = w_rd[WIDTH-1:0];
            out_valid_d = 1'b1;
         end else begin
            // Still filling: emit zeros and count the accepted sample.
            dout_r_d   = '0;
            dout_i_d   = '0;
            fill_cnt_d = fill_cnt_q + c_min_delay;
         end
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         delay_q     <= c_default_delay;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         dout_r_q    <= '0;
         dout_i_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         delay_q     <= delay_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_cnt_q  <= fill_cnt_d;
         dout_r_q    <= dout_r_d;
         dout_i_q    <= dout_i_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Sample storage is not reset; the fill tracker masks stale contents.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem[wr_ptr_q] <= w_din;
      end
   end

   assign dataOut_R = dout_r_q;
   assign dataOut_I = dout_i_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sdf_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdf_delay_line
//  Description : Directed self-checking bench for sdf_delay_line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_delay_line;

   localparam int W  = 24;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          bypass = 1'b0;
   logic          cfg_load = 1'b0;
   logic [AW:0]   delay_sel = '0;
   logic [W-1:0]  dataIn_R = '0;
   logic [W-1:0]  dataIn_I = '0;
   logic [W-1:0]  dataOut_R;
   logic [W-1:0]  dataOut_I;
   logic          out_valid;
   logic [AW:0]   delay_q;

   int n_tests = 0;
   int n_fail  = 0;

   sdf_delay_line #(
      .WIDTH(W), .MAX_DELAY(64), .ADDR_W(AW), .DEFAULT_DELAY(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
`ifdef SDF_DELAY_BYPASS_EN
      .bypass    (bypass),
`endif
      .cfg_load  (cfg_load),
      .delay_sel (delay_sel),
      .dataIn_R  (dataIn_R),
      .dataIn_I  (dataIn_I),
      .dataOut_R (dataOut_R),
      .dataOut_I (dataOut_I),
      .out_valid (out_valid),
      .delay_q   (delay_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the full output triple after an edge.
   task automatic check_out(input string tag, input logic [W-1:0] er, input logic [W-1:0] ei,
                            input logic ev);
      check({tag, ".R"}, 48'(dataOut_R), 48'(er));
      check({tag, ".I"}, 48'(dataOut_I), 48'(ei));
      check({tag, ".V"}, 48'(out_valid), 48'(ev));
   endtask

   // One clock with the given enable/data; returns #1 after the edge.
   task automatic beat(input logic e, input logic [W-1:0] r, input logic [W-1:0] i);
      en = e; dataIn_R = r; dataIn_I = i;
      @(posedge clk); #1;
   endtask

   task automatic load(input logic [AW:0] d, input logic e, input logic [W-1:0] r);
      cfg_load = 1'b1; delay_sel = d; en = e; dataIn_R = r; dataIn_I = r;
      @(posedge clk); #1;
      cfg_load = 1'b0; en = 1'b0;
   endtask

   initial begin
      logic [W-1:0] er;
      logic [W-1:0] ei;

      // ---- reset state ----
      #12;
      check_out("reset", '0, '0, 1'b0);
      check("reset.delay", 48'(delay_q), 48'd8);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---- default delay 8, samples n / -n ----
      for (int n = 1; n <= 20; n++) begin
         beat(1'b1, W'(n), W'(-n));
         if (n <= 8) begin
            check_out("fill8", '0, '0, 1'b0);
         end else begin
            er = W'(n - 8);
            ei = W'(8 - n);
            check_out("lag8", er, ei, 1'b1);
         end
      end

      // ---- load delay 3, stream 10,11,... ----
      load(7'd3, 1'b0, '0);
      check("load3.delay", 48'(delay_q), 48'd3);
      check_out("load3.clear", '0, '0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         beat(1'b1, W'(9 + k), W'(9 + k));
         if (k <= 3) begin
            check_out("fill3", '0, '0, 1'b0);
         end else begin
            er = W'(9 + k - 3);
            check_out("lag3", er, er, 1'b1);
         end
      end

      // ---- delay 2 with toggled enable: A,B,C,D ----
      load(7'd2, 1'b0, '0);
      beat(1'b1, 24'h00A00A, 24'h00A00B);  check_out("tog.A",    '0, '0, 1'b0);
      beat(1'b0, 24'h0FFFFF, 24'h0FFFFF);  check_out("tog.idle1", '0, '0, 1'b0);
      beat(1'b1, 24'h00B00B, 24'h00B00C);  check_out("tog.B",    '0, '0, 1'b0);
      beat(1'b0, 24'h0FFFFF, 24'h0FFFFF);  check_out("tog.idle2", '0, '0, 1'b0);
      beat(1'b1, 24'h00C00C, 24'h00C00D);  check_out("tog.C",    24'h00A00A, 24'h00A00B, 1'b1);
      beat(1'b0, 24'h0FFFFF, 24'h0FFFFF);  check_out("tog.idle3", 24'h00A00A, 24'h00A00B, 1'b0);
      beat(1'b1, 24'h00D00D, 24'h00D00E);  check_out("tog.D",    24'h00B00B, 24'h00B00C, 1'b1);
      beat(1'b0, 24'h0FFFFF, 24'h0FFFFF);  check_out("tog.idle4", 24'h00B00B, 24'h00B00C, 1'b0);

      // ---- clamp low: delay_sel 0 -> 1 ----
      load(7'd0, 1'b0, '0);
      check("clamp0.delay", 48'(delay_q), 48'd1);
      beat(1'b1, 24'h000005, 24'h000015);  check_out("d1.first", '0, '0, 1'b0);
      beat(1'b1, 24'h000006, 24'h000016);  check_out("d1.second", 24'h000005, 24'h000015, 1'b1);
      beat(1'b1, 24'h000007, 24'h000017);  check_out("d1.third", 24'h000006, 24'h000016, 1'b1);

      // ---- clamp high: delay_sel 100 -> 64, 200 samples across wrap ----
      load(7'd100, 1'b0, '0);
      check("clamp100.delay", 48'(delay_q), 48'd64);
      for (int b = 1; b <= 200; b++) begin
         beat(1'b1, W'(1000 + b), W'(5000 + b));
         if (b <= 64) begin
            check_out("fill64", '0, '0, 1'b0);
         end else begin
            er = W'(1000 + b - 64);
            ei = W'(5000 + b - 64);
            check_out("lag64", er, ei, 1'b1);
         end
      end

      // ---- load with en on a full line: sample dropped, refill follows ----
      load(7'd4, 1'b1, 24'h000777);
      check("ldEn.delay", 48'(delay_q), 48'd4);
      check_out("ldEn.clear", '0, '0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         beat(1'b1, W'(24'h500 + k), W'(24'h600 + k));
         if (k <= 4) begin
            check_out("refill4", '0, '0, 1'b0);
         end else begin
            er = W'(24'h500 + k - 4);
            ei = W'(24'h600 + k - 4);
            check_out("lag4", er, ei, 1'b1);
         end
      end

      // ---- asynchronous reset mid-stream ----
      en = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_out("arst", '0, '0, 1'b0);
      check("arst.delay", 48'(delay_q), 48'd8);
      #2 rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         beat(1'b1, W'(24'h900 + k), W'(24'h900 + k));
         if (k <= 8) begin
            check_out("postrst.fill", '0, '0, 1'b0);
         end else begin
            er = W'(24'h900 + k - 8);
            check_out("postrst.lag", er, er, 1'b1);
         end
      end

`ifdef SDF_DELAY_BYPASS_EN
      // ---- bypass: one-clock pass-through, history frozen ----
      load(7'd2, 1'b0, '0);
      beat(1'b1, 24'h000011, 24'h000021);  check_out("byp.pre1", '0, '0, 1'b0);
      bypass = 1'b1;
      beat(1'b1, 24'h00ABCD, 24'h00DCBA);  check_out("byp.pass", 24'h00ABCD, 24'h00DCBA, 1'b1);
      bypass = 1'b0;
      beat(1'b1, 24'h000012, 24'h000022);  check_out("byp.pre2", '0, '0, 1'b0);
      beat(1'b1, 24'h000013, 24'h000023);  check_out("byp.resume", 24'h000011, 24'h000021, 1'b1);
      beat(1'b1, 24'h000014, 24'h000024);  check_out("byp.next", 24'h000012, 24'h000022, 1'b1);
`endif

      en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/sdf_delay_line.md
Name: sdf_delay_line

Overview:
- Complex (R/I) delay line for single-path delay feedback (SDF) FFT stages.
- Successor to the fixed-depth shift-register delay. Depth is selectable at run time up to MAX_DELAY, so one instance serves several FFT sizes.
- Storage is a circular buffer, not a register chain, and only advances on qualified input samples.
- A fill tracker flags when the output carries real data.

Parameters:
- WIDTH, 24, bit width of each of the real and imaginary parts.
- MAX_DELAY, 64, storage depth and largest selectable delay. Must be ≥ 2.
- ADDR_W, 6, pointer width. Must satisfy 2^ADDR_W ≥ MAX_DELAY.
- DEFAULT_DELAY, 8, delay value loaded at reset. Range 1..MAX_DELAY.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  input sample valid; the line advances only when this is high.
- cfg_load  in  1  single-cycle pulse that latches delay_sel and restarts the line.
- delay_sel  in  ADDR_W+1  requested delay in enabled samples.
- dataIn_R  in  WIDTH  input sample, real part.
- dataIn_I  in  WIDTH  input sample, imaginary part.
- dataOut_R  out  WIDTH  delayed sample, real part (registered).
- dataOut_I  out  WIDTH  delayed sample, imaginary part (registered).
- out_valid  out  1  dataOut carries a genuine delayed sample this cycle.
- delay_q  out  ADDR_W+1  currently active delay.
- bypass  in  1  present only with SDF_DELAY_BYPASS_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous):
  - dataOut_R, dataOut_I, out_valid cleared to 0.
  - delay_q set to DEFAULT_DELAY.
  - wr_ptr and fill_cnt set to 0.
  - Memory contents are not reset.
- Clamp on load: delay_sel = 0 is treated as 1; delay_sel > MAX_DELAY is treated as MAX_DELAY.
- cfg_load has priority over en:
  - delay_q takes the clamped value; wr_ptr and fill_cnt go to 0.
  - dataOut is cleared to 0 and out_valid to 0.
  - Any sample presented with en in the same cycle is dropped.
- On an en cycle without cfg_load:
  - rd = mem[wr_ptr], read before the write; then mem[wr_ptr] <= dataIn.
  - wr_ptr <= (wr_ptr == delay_q-1) ? 0 : wr_ptr+1.
  - If fill_cnt == delay_q: dataOut <= rd and out_valid <= 1.
  - Otherwise: dataOut <= 0, out_valid <= 0, and fill_cnt <= fill_cnt+1.
  - fill_cnt saturates at delay_q.
- Net effect: the sample accepted on enabled beat k appears on dataOut on the edge of enabled beat k+delay_q. This equals a shift register of depth delay_q clocked by en.
- On an idle cycle (en = 0, no load):
  - dataOut holds its value.
  - out_valid <= 0, so out_valid is a per-beat pulse.
  - Pointers and fill_cnt hold.
- Delay = 1: wr_ptr stays 0; each enabled sample is output on the next enabled beat.
- Wrap-around: the pointer wraps at delay_q-1, never at MAX_DELAY, so locations at or above delay_q are unused.
- delay_sel is ignored unless cfg_load is high. Changing delay mid-stream therefore always passes through a refill of delay_q enabled beats.
- Reset asserted mid-operation aborts everything immediately. After release, the first delay_q enabled beats output zeros with out_valid = 0.
- Latency in clocks with en held high: delay_q cycles from input to registered output.

Optional Feature:
- Macro: SDF_DELAY_BYPASS_EN.
- When the macro is defined:
  - The bypass port exists.
  - When bypass = 1 and en = 1: dataOut <= dataIn and out_valid <= 1 (one-clock latency). Memory, wr_ptr and fill_cnt hold.
  - cfg_load still has priority over bypass.
  - Bypass is used for the last FFT stage, where the butterfly needs no delay.
- When the macro is undefined:
  - The port is absent and the block behaves as if bypass were 0.
  - No bypass mux appears in the netlist.

Test Plan:
- Reset, then en = 1 every cycle with dataIn_R = n, dataIn_I = -n for n = 1..20, default delay 8 → out_valid = 0 and outputs 0 for the first 8 beats; on beat 9 dataOut_R = 1, dataOut_I = -1, then tracking with lag 8.
- cfg_load with delay_sel = 3, then stream 10,11,12,... → first valid output is 10 on the 4th enabled beat; delay_q reads 3.
- en toggled 1,0,1,0 with delay 2 and samples A,B,C,D → outputs hold on idle cycles; A appears on the enabled beat carrying C; out_valid is high only on enabled beats.
- delay_sel = 0 reads back delay_q = 1; delay_sel = 100 reads back delay_q = 64. With delay 64, stream 200 samples: sample k appears at beat k+64, including across the pointer wrap.
- cfg_load asserted together with en = 1 while the line is filled → that sample is lost, out_valid drops to 0, and a full refill follows. Assert rst mid-stream → outputs are 0 immediately, asynchronously.
- With SDF_DELAY_BYPASS_EN defined: bypass = 1, en = 1, dataIn_R = 0x00ABCD → next cycle dataOut_R = 0x00ABCD and out_valid = 1. After bypass drops, delayed data resumes from the point where bypass began.
